// File: rtl/mem_arbiter_if.sv
// Bundle of the core-side request/response signals and the shared RAM port
// seen by mem_arbiter. The arbiter uses the slave view; the core/RAM side
// (or a testbench) uses the master view.
interface mem_arbiter_if;
  // instruction-fetch request
  logic        iREN;
  logic [31:0] iaddr;
  // data request
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  // responses to the core
  logic        iwait;
  logic        dwait;
  logic [31:0] iload;
  logic [31:0] dload;
  // shared RAM port
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;
  // error status
  logic        memerr;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for one MIPS core: serialises instruction fetch and
// data accesses onto one RAM port with data priority, a starvation limit that
// forces an instruction grant, and an access timeout that returns ERRWORD and
// sets a sticky error flag.
module mem_arbiter #(
  parameter int unsigned MAX_STARVE = 3,
  parameter int unsigned TIMEOUT    = 64,
  parameter logic [31:0] ERRWORD    = 32'hBAD1BAD1
) (
  input logic          CLK,
  input logic          RST,
  mem_arbiter_if.slave bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IACC = 2'd1,
    ST_DACC = 2'd2
  } state_e;

  state_e        state_q,    state_d;
  logic [SW-1:0] starve_q,   starve_d;
  logic [TW-1:0] tmo_q,      tmo_d;
  logic          memerr_q,   memerr_d;
  logic          ren_q,      ren_d;
  logic          wen_q,      wen_d;
  logic [DW-1:0] addr_q,     addr_d;
  logic [DW-1:0] store_q,    store_d;

  logic          d_req_c;
  logic          i_forced_c;
  logic          tmo_hit_c;
  logic          iwait_c;
  logic          dwait_c;
  logic [DW-1:0] iload_c;
  logic [DW-1:0] dload_c;

  // Request decode: a data request wins unless the fetch has waited too long.
  always_comb begin
    d_req_c    = bus.dREN | bus.dWEN;
    i_forced_c = bus.iREN && (starve_q == STARVE_MAX);
    tmo_hit_c  = (tmo_q == TMO_LAST) && !bus.ramready;
  end

  // Next-state logic and the combinational completion outputs.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    tmo_d    = tmo_q;
    memerr_d = memerr_q;
    ren_d    = ren_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    store_d  = store_q;
    iwait_c  = 1'b1;
    dwait_c  = 1'b1;
    iload_c  = '0;
    dload_c  = '0;

    unique case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (d_req_c && !i_forced_c) begin
          state_d = ST_DACC;
          addr_d  = bus.daddr;
          store_d = bus.dstore;
          // A simultaneous read+write request is a write.
          wen_d   = bus.dWEN;
          ren_d   = !bus.dWEN;
          // Cannot overflow: at STARVE_MAX with iREN high the fetch is granted.
          if (bus.iREN) starve_d = starve_q + SW'(1);
          else          starve_d = '0;
        end else if (bus.iREN) begin
          state_d  = ST_IACC;
          addr_d   = bus.iaddr;
          ren_d    = 1'b1;
          wen_d    = 1'b0;
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
      end

      ST_IACC, ST_DACC: begin
        if (bus.ramready || tmo_hit_c) begin
          if (state_q == ST_IACC) begin
            iwait_c = 1'b0;
            iload_c = bus.ramready ? bus.ramload : ERRWORD;
          end else begin
            dwait_c = 1'b0;
            if (!bus.ramready) dload_c = ERRWORD;
            else if (wen_q)    dload_c = '0;
            else               dload_c = bus.ramload;
          end
          if (tmo_hit_c) memerr_d = 1'b1;
          state_d = ST_IDLE;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
        tmo_d   = '0;
      end
    endcase
  end

  // State and RAM-port registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      tmo_q    <= '0;
      memerr_q <= 1'b0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
      memerr_q <= memerr_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
    end
  end

  // Drive the interface: RAM side straight from registers, core side from the
  // completion decode so a ready RAM releases the stall in the same cycle.
  always_comb begin
    bus.ramREN   = ren_q;
    bus.ramWEN   = wen_q;
    bus.ramaddr  = addr_q;
    bus.ramstore = store_q;
    bus.memerr   = memerr_q;
    bus.iwait    = iwait_c;
    bus.dwait    = dwait_c;
    bus.iload    = iload_c;
    bus.dload    = dload_c;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Single-port RAM arbiter for one MIPS core. It sits between the instruction-fetch path and the data path (driven by the decoded icuREN, dcuREN and dcuWEN strobes) and the one shared RAM port. It serialises requests with data priority. A starvation counter guarantees instruction fetch progress, and a timeout recovers from a RAM that never responds.

Parameters:
MAX_STARVE, 3, number of consecutive data grants allowed while an instruction request waits; the next grant then goes to the instruction request.
TIMEOUT, 64, number of cycles in an access state without ramready before the access is aborted.
ERRWORD, 32'hBAD1BAD1, value returned on the load bus for an aborted access.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RST  in  1  synchronous, active-high reset.
iREN  in  1  instruction read request.
iaddr  in  32  instruction address.
dREN  in  1  data read request.
dWEN  in  1  data write request.
daddr  in  32  data address.
dstore  in  32  data write value.
iwait  out  1  instruction stall; 0 only in the completing cycle.
dwait  out  1  data stall; 0 only in the completing cycle.
iload  out  32  instruction word; valid when iwait=0.
dload  out  32  load data; valid when dwait=0.
ramREN  out  1  RAM read strobe (registered).
ramWEN  out  1  RAM write strobe (registered).
ramaddr  out  32  RAM address (registered).
ramstore  out  32  RAM write data (registered).
ramload  in  32  RAM read data.
ramready  in  1  RAM completion, one cycle per access.
memerr  out  1  sticky flag: a timeout has occurred.

Behaviour:
- Reset (RST=1 at an edge):
  - state=IDLE; ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - starve_cnt=0, tmo_cnt=0, memerr=0.
  - iwait=1, dwait=1, iload=0, dload=0.
  - Reset mid-access drops the RAM strobes at that edge; no completion is reported.
- FSM states: IDLE, IACC, DACC.
- IDLE:
  - Requests are sampled at the edge.
  - If (dREN|dWEN) and not (iREN and starve_cnt==MAX_STARVE): go to DACC. Latch daddr and dstore. If dWEN, set ramWEN=1; otherwise set ramREN=1.
  - Else if iREN: go to IACC. Latch iaddr; set ramREN=1.
  - Else stay in IDLE.
- Data request with dWEN=1 and dREN=1: treated as a write only.
- Starvation counter:
  - On a DACC grant with iREN=1: starve_cnt+1, saturating at MAX_STARVE.
  - On an IACC grant, or in IDLE with iREN=0: starve_cnt=0.
- IACC/DACC:
  - Strobes, address and store data are held stable. tmo_cnt increments each cycle.
  - When ramready=1 (combinational path), the owner's wait drops to 0 in that same cycle. The owner's load output equals ramload in that cycle (0 for a write).
  - At the next edge: return to IDLE, drop the strobes, tmo_cnt=0.
- Latency:
  - Request at cycle N gives strobes at N+1. With ramready at N+1, wait=0 at N+1.
  - There is one mandatory IDLE turnaround cycle between accesses, so back-to-back accesses start at most every 2 cycles.
- Timeout: if tmo_cnt reaches TIMEOUT-1 with ramready=0:
  - The owner's wait=0 for one cycle, with load=ERRWORD.
  - Set memerr=1 (sticky until RST). Return to IDLE.
- A requester that deasserts its request mid-access does not abort the access. It completes normally and the result is still presented.
- A wait signal never drops for the non-owner. iwait and dwait are never both 0 in the same cycle.
- ramready in IDLE is ignored.

Test Plan:
- Instruction fetch only: iREN=1, iaddr=0x40, ramready 2 cycles after the strobe, ramload=0x3C010001 -> ramREN=1 and ramaddr=0x40 from cycle 1; iwait=0 and iload=0x3C010001 exactly in the ramready cycle; ramREN=0 the next cycle.
- Simultaneous requests: iREN=1 and dREN=1 (daddr=0x100) at the same edge -> DACC granted first. dload=ramload. The IACC grant occurs after the one-cycle IDLE turnaround.
- Starvation: iREN held at 1 and dREN held at 1, every access 1-cycle ready -> the grant order is D,D,D,I,D,D,D,I.
- Write with read: dWEN=1 and dREN=1, daddr=0x200, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait=0 on ramready.
- Timeout: dREN=1, ramready never asserted -> dwait=0 with dload=0xBAD1BAD1 in cycle 64 of DACC; memerr=1 and stays 1. A subsequent iREN is served normally.
- Reset mid-access: RST=1 during IACC -> strobes are 0 after the edge, iwait stays 1, memerr=0, starve_cnt=0; a following fetch behaves as in scenario 1.
